// File: rtl/bpsk_phase_gen_pkg.sv
// bpsk_phase_gen_pkg: shared defaults, derived constants and FSM state type for the BPSK phase generator
package bpsk_phase_gen_pkg;
   localparam int DATA_WIDTH_DEF      = 12;
   localparam int SINE_RESOLUTION_DEF = 20;
   localparam int CYCLES_PER_BIT_DEF  = 2;
   localparam int HALF_RES            = SINE_RESOLUTION_DEF / 2;
   typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/bpsk_symbol_timer.sv
// bpsk_symbol_timer: carrier phase and period counters marking the last cycle of each symbol
module bpsk_symbol_timer #(
   parameter int DATA_WIDTH      = 12,
   parameter int SINE_RESOLUTION = 20,
   parameter int CYCLES_PER_BIT  = 2,
   parameter int PW              = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   input  logic                  load,
   output logic [DATA_WIDTH-1:0] phase_cnt,
   output logic [PW-1:0]         period_cnt,
   output logic                  last
);
   localparam logic [DATA_WIDTH-1:0] LAST_PH  = DATA_WIDTH'(SINE_RESOLUTION - 1);
   localparam logic [PW-1:0]         LAST_PER = PW'(CYCLES_PER_BIT - 1);
   logic wrap;
   assign wrap = phase_cnt == LAST_PH;
   assign last = run && wrap && period_cnt == LAST_PER;
   // step the phase every running cycle and the period on each phase wrap; a transfer restarts both
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_cnt  <= '0;
         period_cnt <= '0;
      end else if (load) begin
         phase_cnt  <= '0;
         period_cnt <= '0;
      end else if (run) begin
         phase_cnt <= wrap ? '0 : phase_cnt + 1'b1;
         if (wrap) period_cnt <= period_cnt == LAST_PER ? '0 : period_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/bpsk_phase_gen.sv
// bpsk_phase_gen: BPSK sine-table phase source; define BPSK_DIFF_EN for differential encoding
module bpsk_phase_gen
   import bpsk_phase_gen_pkg::*;
#(
   parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int SINE_RESOLUTION = SINE_RESOLUTION_DEF,
   parameter int CYCLES_PER_BIT  = CYCLES_PER_BIT_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bit_data,
   input  logic                  bit_valid,
   output logic                  bit_ready,
   output logic [DATA_WIDTH-1:0] phase,
   output logic                  phase_valid,
   output logic                  symbol_start
);
   localparam int PW = CYCLES_PER_BIT > 1 ? $clog2(CYCLES_PER_BIT) : 1;
   localparam logic [DATA_WIDTH-1:0] HALF  = DATA_WIDTH'(SINE_RESOLUTION / 2);
   localparam logic [DATA_WIDTH:0]   RES_X = (DATA_WIDTH + 1)'(SINE_RESOLUTION);
   state_t state, state_next;
   logic [DATA_WIDTH-1:0] phase_cnt, cur_offset, new_offset, phase_next;
   logic [PW-1:0] period_cnt;
   logic last, xfer;
   logic [DATA_WIDTH:0] sum;
   bpsk_symbol_timer #(
      .DATA_WIDTH(DATA_WIDTH),
      .SINE_RESOLUTION(SINE_RESOLUTION),
      .CYCLES_PER_BIT(CYCLES_PER_BIT),
      .PW(PW)
   ) u_timer (
      .clk(clk),
      .rst_n(rst_n),
      .run(state == RUN),
      .load(xfer),
      .phase_cnt(phase_cnt),
      .period_cnt(period_cnt),
      .last(last)
   );
   assign bit_ready = state == IDLE || last;
   assign xfer      = bit_valid && bit_ready;
`ifdef BPSK_DIFF_EN
   logic [DATA_WIDTH-1:0] prev_offset;
   assign new_offset = bit_data ? prev_offset : (prev_offset == '0 ? HALF : '0);
   // remember the last transmitted offset so each zero bit flips the carrier; survives underflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_offset <= '0;
      else if (xfer) prev_offset <= new_offset;
   end
`else
   assign new_offset = bit_data ? '0 : HALF;
`endif
   // next state: leave IDLE on a transfer, fall back to IDLE when a symbol ends with no new bit
   always_comb begin
      state_next = state;
      state_next = state == IDLE ? (xfer ? RUN : IDLE) : (last && !xfer ? IDLE : RUN);
   end
   // table index with the symbol offset folded back into 0..SINE_RESOLUTION-1
   always_comb begin
      sum        = {1'b0, phase_cnt} + {1'b0, cur_offset};
      phase_next = DATA_WIDTH'(sum >= RES_X ? sum - RES_X : sum);
   end
   // state register and offset captured with each accepted bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cur_offset <= '0;
      end else begin
         state <= state_next;
         if (xfer) cur_offset <= new_offset;
      end
   end
   // registered outputs, one cycle behind the counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase        <= '0;
         phase_valid  <= 1'b0;
         symbol_start <= 1'b0;
      end else begin
         phase        <= state == RUN ? phase_next : '0;
         phase_valid  <= state == RUN;
         symbol_start <= state == RUN && phase_cnt == '0 && period_cnt == '0;
      end
   end
endmodule
